// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencers: state encoding,
// bus idle levels and default phase durations (also used by the read side).
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_PULSE,
    A_HOLD,
    GAP,
    D_SETUP,
    D_PULSE,
    D_HOLD,
    DONE
  } estado_t;

  localparam logic CS_IDLE = 1'b1;
  localparam logic WR_IDLE = 1'b1;
  localparam logic RD_IDLE = 1'b1;
  localparam logic AD_IDLE = 1'b1;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 10;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 10;
  localparam int CNT_W_DEF   = 7;

  // Fixed phase order of a bus cycle; DONE always falls back to IDLE.
  function automatic estado_t siguiente(input estado_t s);
    case (s)
      IDLE:    return A_SETUP;
      A_SETUP: return A_PULSE;
      A_PULSE: return A_HOLD;
      A_HOLD:  return GAP;
      GAP:     return D_SETUP;
      D_SETUP: return D_PULSE;
      D_PULSE: return D_HOLD;
      D_HOLD:  return DONE;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fsm_escritura_rtc_temporizador_fase.sv
// Phase timer: loadable down-counter that reports fin when it reaches zero.
module temporizador_fase #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             fin
);

  logic [CNT_W-1:0] cuenta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= '0;
    end else if (load) begin
      cuenta <= value;
    end else if (dec && (cuenta != '0)) begin
      cuenta <= cuenta - CNT_W'(1);
    end
  end

  assign fin = (cuenta == '0);

endmodule

// File: rtl/fsm_escritura_rtc.sv
// RTC bus write-cycle generator: address phase, bus gap, data phase, done pulse.
// Optional sticky overrun flag enabled by defining FSM_ESC_OVERRUN_EN.
module fsm_escritura_rtc
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [7:0] direccion,
  input  logic [7:0] dato,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       busy,
  output logic       listo,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

  estado_t          estado;
  logic [7:0]       dir_q;
  logic [7:0]       dato_q;
  logic             carga;
  logic             decre;
  logic [CNT_W-1:0] valor;
  logic             fin;

  function automatic logic [CNT_W-1:0] duracion(input estado_t s);
    case (s)
      A_SETUP, D_SETUP: return LD_SETUP;
      A_PULSE, D_PULSE: return LD_PULSE;
      A_HOLD,  D_HOLD:  return LD_HOLD;
      GAP:              return LD_GAP;
      default:          return '0;
    endcase
  endfunction

  // Timer is reloaded with the length of the state being entered.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    carga = 1'b0;
    decre = 1'b0;
    valor = LD_SETUP;
    case (estado)
      IDLE: carga = inicio;
      DONE: ;
      default: begin
        if (fin) begin
          carga = 1'b1;
          valor = duracion(siguiente(estado));
        end else begin
          decre = 1'b1;
        end
      end
    endcase
  end

  temporizador_fase #(.CNT_W(CNT_W)) u_temporizador (
    .clk   (clk),
    .reset (reset),
    .load  (carga),
    .value (valor),
    .dec   (decre),
    .fin   (fin)
  );

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado  <= IDLE;
      dir_q   <= '0;
      dato_q  <= '0;
      cs_n    <= CS_IDLE;
      wr_n    <= WR_IDLE;
      ad      <= AD_IDLE;
      bus_out <= '0;
      bus_oe  <= 1'b0;
      busy    <= 1'b0;
      listo   <= 1'b0;
`ifdef FSM_ESC_OVERRUN_EN
      overrun <= 1'b0;
`endif
    end else begin
      case (estado)
        IDLE: begin
          if (inicio) begin
            dir_q  <= direccion;
            dato_q <= dato;
            estado <= A_SETUP;
          end
        end
        DONE:    estado <= IDLE;
        default: if (fin) estado <= siguiente(estado);
      endcase

`ifdef FSM_ESC_OVERRUN_EN
      if (inicio) overrun <= (estado != IDLE);
`endif

      cs_n    <= CS_IDLE;
      wr_n    <= WR_IDLE;
      ad      <= AD_IDLE;
      bus_out <= '0;
      bus_oe  <= 1'b0;
      busy    <= (estado != IDLE);
      listo   <= 1'b0;
      case (estado)
        A_SETUP, A_PULSE, A_HOLD: begin
          cs_n    <= 1'b0;
          ad      <= 1'b0;
          bus_oe  <= 1'b1;
          bus_out <= dir_q;
          wr_n    <= (estado != A_PULSE);
        end
        D_SETUP, D_PULSE, D_HOLD: begin
          cs_n    <= 1'b0;
          bus_oe  <= 1'b1;
          bus_out <= dato_q;
          wr_n    <= (estado != D_PULSE);
        end
        DONE:    listo <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_n = RD_IDLE;

`ifndef FSM_ESC_OVERRUN_EN
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_escritura_rtc.sv
// Bench for fsm_escritura_rtc: default and all-ones timing instances share stimulus,
// each checked every cycle against a phase-offset model of the write cycle.
module tb_fsm_escritura_rtc;

`ifdef FSM_ESC_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inicio = 1'b0;
  logic [7:0] direccion = '0;
  logic [7:0] dato = '0;
  wire  [15:0] obs0;
  wire  [15:0] obs1;

  int vectors = 0;
  int miscompares = 0;
  int e = 0;

  bit         m_act   [2];
  int         m_start [2];
  logic [7:0] m_dir   [2];
  logic [7:0] m_dat   [2];
  logic       m_ovr   [2];

  always #5 clk = ~clk;

  fsm_escritura_rtc u_dut0 (
    .clk(clk), .reset(reset), .inicio(inicio), .direccion(direccion), .dato(dato),
    .cs_n(obs0[15]), .rd_n(obs0[14]), .wr_n(obs0[13]), .ad(obs0[12]),
    .bus_out(obs0[11:4]), .bus_oe(obs0[3]), .busy(obs0[2]), .listo(obs0[1]),
    .overrun(obs0[0])
  );

  fsm_escritura_rtc #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .inicio(inicio), .direccion(direccion), .dato(dato),
    .cs_n(obs1[15]), .rd_n(obs1[14]), .wr_n(obs1[13]), .ad(obs1[12]),
    .bus_out(obs1[11:4]), .bus_oe(obs1[3]), .busy(obs1[2]), .listo(obs1[1]),
    .overrun(obs1[0])
  );

  function automatic int t_s(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int t_p(int i); return (i == 0) ? 10 : 1; endfunction
  function automatic int t_h(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int t_g(int i); return (i == 0) ? 10 : 1; endfunction

  // Cycles from the accepting edge to the listo pulse.
  function automatic int lat(int i);
    return 1 + 2 * (t_s(i) + t_p(i) + t_h(i)) + t_g(i);
  endfunction

  function automatic void update(int i);
    bit idle;
    idle = !m_act[i] || (e >= m_start[i] + lat(i) + 1);
    if (reset) begin
      m_act[i] = 1'b0;
      m_ovr[i] = 1'b0;
    end else if (inicio) begin
      if (idle) begin
        m_act[i]   = 1'b1;
        m_start[i] = e;
        m_dir[i]   = direccion;
        m_dat[i]   = dato;
        m_ovr[i]   = 1'b0;
      end else if (OVR_EN) begin
        m_ovr[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [15:0] expect_out(int i);
    int s, p, a, g, t, u;
    logic cs, wr, ad, oe, bz, ls;
    logic [7:0] bo;
    s = t_s(i);
    p = t_p(i);
    a = s + p + t_h(i);
    g = t_g(i);
    cs = 1'b1; wr = 1'b1; ad = 1'b1; oe = 1'b0; bz = 1'b0; ls = 1'b0; bo = '0;
    if (m_act[i]) begin
      t = e - m_start[i];
      if (t >= 1 && t <= lat(i)) bz = 1'b1;
      if (t >= 1 && t <= a) begin
        cs = 1'b0; ad = 1'b0; oe = 1'b1; bo = m_dir[i];
        wr = !(t > s && t <= s + p);
      end else if (t > a + g && t <= 2 * a + g) begin
        u = t - a - g;
        cs = 1'b0; oe = 1'b1; bo = m_dat[i];
        wr = !(u > s && u <= s + p);
      end else if (t == lat(i)) begin
        ls = 1'b1;
      end
    end
    return {cs, 1'b1, wr, ad, bo, oe, bz, ls, m_ovr[i]};
  endfunction

  task automatic check(int i);
    logic [15:0] obs;
    logic [15:0] exp_v;
    obs   = (i == 0) ? obs0 : obs1;
    exp_v = expect_out(i);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL dut%0d cyc=%0d {cs,rd,wr,ad,bus,oe,busy,listo,ovr} observed=%h expected=%h",
             i, e, obs, exp_v);
    end
  endtask

  task automatic step(int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      e++;
      update(0);
      update(1);
      #1;
      check(0);
      check(1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_start[i] = 0; m_dir[i] = '0; m_dat[i] = '0; m_ovr[i] = 1'b0;
    end

    // Reset held three cycles, then idle.
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(5);

    // Single write 21/45.
    direccion = 8'h21; dato = 8'h45; inicio = 1'b1;
    step(1);
    inicio = 1'b0; direccion = 8'h00; dato = 8'h00;
    step(45);

    // Request held high: back-to-back cycles with one idle cycle between.
    direccion = 8'h3C; dato = 8'hC3; inicio = 1'b1;
    step(100);
    inicio = 1'b0;
    step(45);

    // Extra request mid-cycle must not disturb the latched values.
    direccion = 8'h21; dato = 8'h45; inicio = 1'b1;
    step(1);
    inicio = 1'b0;
    step(4);
    direccion = 8'h10; dato = 8'h99; inicio = 1'b1;
    step(1);
    inicio = 1'b0;
    step(45);

    // Reset during the data strobe of the default-timing instance.
    direccion = 8'h5A; dato = 8'hA5; inicio = 1'b1;
    step(1);
    inicio = 1'b0;
    step(29);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(50);

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      inicio    = ($urandom_range(0, 5) == 0);
      direccion = 8'($urandom);
      dato      = 8'($urandom);
      reset     = ($urandom_range(0, 149) == 0);
      step(1);
    end
    reset = 1'b0;
    inicio = 1'b0;
    step(45);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
